riscv_v_twos_comp_pipe: RTL



---
 rtl/riscv_v_twos_comp_pipe_pkg.sv | 44 ++++
 rtl/riscv_v_tc_pipe_chk.sv | 14 +
 rtl/riscv_v_tc_seg_adder.sv | 62 ++++++
 rtl/riscv_v_twos_comp_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_twos_comp_pipe_pkg.sv
// Shared vector-unit types and helpers for the two's-complement pipe.
package riscv_v_pkg;

    localparam int BYTE_WIDTH               = 8;
    localparam int RISCV_V_NUM_BYTES_DATA   = 16;
    localparam int RISCV_V_NUM_VALID_OSIZES = 4;
    localparam int TC_PIPE_LATENCY          = 2;

    typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_vector_t;
    typedef logic [RISCV_V_NUM_BYTES_DATA-1:0]   lane_mask_t;

    typedef enum logic [1:0] {
        TC_PASS    = 2'd0,
        TC_NEG     = 2'd1,
        TC_ABS     = 2'd2,
        TC_NEG_SAT = 2'd3
    } riscv_v_tc_op_t;

    // Map a one-hot osize to its log2 lane count; anything illegal falls back to byte elements.
    function automatic logic [1:0] osize_to_idx(input osize_vector_t osize);
        logic [1:0] idx;
        case (osize)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lanes that hold the least-significant byte of an element of size 2^idx lanes.
    function automatic lane_mask_t elem_lsb_mask(input logic [1:0] idx);
        lane_mask_t m;
        int         lanes;
        m     = {RISCV_V_NUM_BYTES_DATA{1'b0}};
        lanes = 32'sd1 << idx;
        for (int i = 0; i < RISCV_V_NUM_BYTES_DATA; i++) begin
            m[i] = ((i % lanes) == 0);
        end
        return m;
    endfunction

endpackage

// File: rtl/riscv_v_tc_pipe_chk.sv
// Protocol checker for the two's-complement pipe input side.
module riscv_v_tc_pipe_chk #(
    parameter int NUM_OSIZES = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  in_valid,
    input logic [NUM_OSIZES-1:0] in_osize
);

    // An offered beat must carry exactly one element-size bit.
    osize_onehot_a: assert property (@(posedge clk) disable iff (rst) in_valid |-> $onehot(in_osize));

endmodule

// File: rtl/riscv_v_tc_seg_adder.sv
// Segmented per-lane incrementer: complements masked lanes, adds one at each
// element's LSB, ripples carries only inside an element, and saturates
// most-negative elements to max positive when requested.
module riscv_v_tc_seg_adder
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES   = RISCV_V_NUM_BYTES_DATA,
    parameter int BLOCK_WIDTH = BYTE_WIDTH
) (
    input  logic [NUM_BYTES*BLOCK_WIDTH-1:0] data_in,
    input  logic [NUM_BYTES-1:0]             mask,
    input  logic [NUM_BYTES-1:0]             most_neg,
    input  logic [1:0]                       osize_idx,
    input  logic                             sat,
    output logic [NUM_BYTES*BLOCK_WIDTH-1:0] data_out,
    output logic [NUM_BYTES-1:0]             ovf
);

    localparam logic [BLOCK_WIDTH-1:0] LANE_MAX_POS = {1'b0, {(BLOCK_WIDTH-1){1'b1}}};
    localparam logic [BLOCK_WIDTH-1:0] LANE_ONES    = {BLOCK_WIDTH{1'b1}};

    lane_mask_t             lsb_full_s;
    logic [NUM_BYTES-1:0]   lsb_s;
    logic [NUM_BYTES-1:0]   top_s;
    logic                   carry_s;
    logic                   cin_s;
    logic                   sat_run_s;
    logic [BLOCK_WIDTH:0]   sum_s;

    // Ripple through lanes LSB-first, restarting the carry at every element boundary.
    always_comb begin
        lsb_full_s = elem_lsb_mask(osize_idx);
        lsb_s      = lsb_full_s[NUM_BYTES-1:0];
        top_s      = {1'b1, lsb_s[NUM_BYTES-1:1]};
        carry_s    = 1'b0;
        cin_s      = 1'b0;
        sat_run_s  = 1'b0;
        sum_s      = {(BLOCK_WIDTH+1){1'b0}};
        data_out   = {(NUM_BYTES*BLOCK_WIDTH){1'b0}};
        ovf        = {NUM_BYTES{1'b0}};
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lsb_s[i]) begin
                cin_s     = mask[i];
                ovf[i]    = mask[i] & most_neg[i];
                sat_run_s = sat & mask[i] & most_neg[i];
            end else begin
                cin_s     = carry_s;
                ovf[i]    = 1'b0;
                sat_run_s = sat_run_s;
            end
            sum_s   = {1'b0, data_in[i*BLOCK_WIDTH +: BLOCK_WIDTH] ^ {BLOCK_WIDTH{mask[i]}}}
                    + {{BLOCK_WIDTH{1'b0}}, cin_s};
            carry_s = sum_s[BLOCK_WIDTH];
            if (sat_run_s) begin
                data_out[i*BLOCK_WIDTH +: BLOCK_WIDTH] = top_s[i] ? LANE_MAX_POS : LANE_ONES;
            end else begin
                data_out[i*BLOCK_WIDTH +: BLOCK_WIDTH] = sum_s[BLOCK_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/riscv_v_twos_comp_pipe.sv
// Two-stage valid/ready pipe computing pass / negate / abs / saturating negate
// on lane-packed vector elements of 8..64 bits.
module riscv_v_twos_comp_pipe
    import riscv_v_pkg::*;
#(
    parameter int NUM_BYTES   = RISCV_V_NUM_BYTES_DATA,
    parameter int BLOCK_WIDTH = BYTE_WIDTH,
    parameter int NUM_OSIZES  = RISCV_V_NUM_VALID_OSIZES,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_BYTES*BLOCK_WIDTH-1:0] in_data,
    input  logic [NUM_BYTES-1:0]             in_en,
    input  logic [NUM_OSIZES-1:0]            in_osize,
    input  riscv_v_tc_op_t                   in_op,
    input  logic [TAG_WIDTH-1:0]             in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_BYTES*BLOCK_WIDTH-1:0] out_data,
    output logic [NUM_BYTES-1:0]             out_ovf,
    output logic [TAG_WIDTH-1:0]             out_tag
);

    localparam int DW = NUM_BYTES*BLOCK_WIDTH;
    localparam logic [BLOCK_WIDTH-1:0] LANE_MIN  = {1'b1, {(BLOCK_WIDTH-1){1'b0}}};
    localparam logic [BLOCK_WIDTH-1:0] LANE_ZERO = {BLOCK_WIDTH{1'b0}};

    // Handshake
    logic s1_adv_s;
    logic s2_adv_s;
    logic s1_valid_r;
    logic s2_valid_r;

    // S1 decode
    logic [1:0]             osize_idx_s;
    lane_mask_t             lsb_full_s;
    logic [NUM_BYTES-1:0]   lsb_s;
    logic [NUM_BYTES-1:0]   top_s;
    logic [NUM_BYTES-1:0]   sign_lane_s;
    logic [NUM_BYTES-1:0]   mask_s;
    logic [NUM_BYTES-1:0]   most_neg_s;
    logic [BLOCK_WIDTH-1:0] lane_s;
    logic                   sign_run_s;
    logic                   mn_run_s;
    logic                   en_run_s;

    // S1 registers
    logic [DW-1:0]          s1_data_r;
    logic [NUM_BYTES-1:0]   s1_mask_r;
    logic [NUM_BYTES-1:0]   s1_most_neg_r;
    logic [1:0]             s1_osize_r;
    logic                   s1_sat_r;
    logic [TAG_WIDTH-1:0]   s1_tag_r;

    // S2 datapath and registers
    logic [DW-1:0]          sum_data_s;
    logic [NUM_BYTES-1:0]   sum_ovf_s;
    logic [DW-1:0]          out_data_r;
    logic [NUM_BYTES-1:0]   out_ovf_r;
    logic [TAG_WIDTH-1:0]   out_tag_r;

    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign s1_adv_s  = s2_adv_s || !s1_valid_r;
    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign out_tag   = out_tag_r;

    // Decode per-lane complement mask and per-element most-negative flag from the offered beat.
    always_comb begin
        osize_idx_s = osize_to_idx(in_osize);
        lsb_full_s  = elem_lsb_mask(osize_idx_s);
        lsb_s       = lsb_full_s[NUM_BYTES-1:0];
        top_s       = {1'b1, lsb_s[NUM_BYTES-1:1]};
        sign_lane_s = {NUM_BYTES{1'b0}};
        most_neg_s  = {NUM_BYTES{1'b0}};
        mask_s      = {NUM_BYTES{1'b0}};
        lane_s      = LANE_ZERO;
        sign_run_s  = 1'b0;
        mn_run_s    = 1'b0;
        en_run_s    = 1'b0;
        // Top-down walk: sign and most-negative are settled by the time the LSB lane is reached.
        for (int i = NUM_BYTES-1; i >= 0; i--) begin
            lane_s = in_data[i*BLOCK_WIDTH +: BLOCK_WIDTH];
            if (top_s[i]) begin
                sign_run_s = lane_s[BLOCK_WIDTH-1];
                mn_run_s   = (lane_s == LANE_MIN);
            end else begin
                mn_run_s   = mn_run_s & (lane_s == LANE_ZERO);
            end
            sign_lane_s[i] = sign_run_s;
            most_neg_s[i]  = lsb_s[i] & mn_run_s;
        end
        // Bottom-up walk: the enable sampled at the LSB lane covers the whole element.
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (lsb_s[i]) begin
                en_run_s = in_en[i];
            end else begin
                en_run_s = en_run_s;
            end
            case (in_op)
                TC_PASS:    mask_s[i] = 1'b0;
                TC_NEG:     mask_s[i] = en_run_s;
                TC_NEG_SAT: mask_s[i] = en_run_s;
                TC_ABS:     mask_s[i] = en_run_s & sign_lane_s[i];
                default:    mask_s[i] = 1'b0;
            endcase
        end
    end

    // Stage valid bits; reset drops anything in flight including a beat offered in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end
        end
    end

    // Capture the decoded beat into S1 on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_r     <= {DW{1'b0}};
            s1_mask_r     <= {NUM_BYTES{1'b0}};
            s1_most_neg_r <= {NUM_BYTES{1'b0}};
            s1_osize_r    <= 2'd0;
            s1_sat_r      <= 1'b0;
            s1_tag_r      <= {TAG_WIDTH{1'b0}};
        end else if (in_valid && s1_adv_s) begin
            s1_data_r     <= in_data;
            s1_mask_r     <= mask_s;
            s1_most_neg_r <= most_neg_s;
            s1_osize_r    <= osize_idx_s;
            s1_sat_r      <= (in_op == TC_NEG_SAT);
            s1_tag_r      <= in_tag;
        end
    end

    riscv_v_tc_seg_adder #(
        .NUM_BYTES   (NUM_BYTES),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_seg_adder (
        .data_in   (s1_data_r),
        .mask      (s1_mask_r),
        .most_neg  (s1_most_neg_r),
        .osize_idx (s1_osize_r),
        .sat       (s1_sat_r),
        .data_out  (sum_data_s),
        .ovf       (sum_ovf_s)
    );

    // Output registers load only when S2 moves and S1 holds a beat, so they hold under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= {DW{1'b0}};
            out_ovf_r  <= {NUM_BYTES{1'b0}};
            out_tag_r  <= {TAG_WIDTH{1'b0}};
        end else if (s2_adv_s && s1_valid_r) begin
            out_data_r <= sum_data_s;
            out_ovf_r  <= sum_ovf_s;
            out_tag_r  <= s1_tag_r;
        end
    end

    riscv_v_tc_pipe_chk #(
        .NUM_OSIZES (NUM_OSIZES)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_osize (in_osize)
    );

endmodule
